// File: rtl/addsub_result_stage.sv
// Registered result/flag stage behind the ripple-carry adder/subtractor: 2-entry FIFO,
// per-entry status flags, an independent re-check of the adder answer, and bring-up counters.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | no entry buffered, out_valid low
// S_ONE   | head entry valid, tail slot free
// S_FULL  | head and tail valid, upstream stalled
module addsub_result_stage #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_ca,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_borrow,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic             out_err,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] op_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_sticky
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             borrow;
        logic             zero;
        logic             neg;
        logic             ovf;
        logic             err;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    entry_t           head_q, head_d, tail_q, tail_d, new_entry;
    logic             in_ready_q;
    logic             push, pop;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   check;
    logic [CNT_W-1:0] op_count_q, err_count_q;
    logic             err_sticky_q;

    assign out_valid = (state_q != S_EMPTY);
    assign in_ready  = in_ready_q;
    assign push      = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    // Flags are frozen at capture so the entry carries its own status downstream.
    always_comb begin
        b_eff            = in_sub ? ~in_b : in_b;
        check            = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, in_sub};
        new_entry.result = in_sum;
        new_entry.carry  = in_ca;
        new_entry.borrow = in_sub & ~in_ca;
        new_entry.zero   = (in_sum == '0);
        new_entry.neg    = in_sum[WIDTH-1];
        if (in_sub) begin
            new_entry.ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) & (in_sum[WIDTH-1] != in_a[WIDTH-1]);
        end else begin
            new_entry.ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (in_sum[WIDTH-1] != in_a[WIDTH-1]);
        end
        new_entry.err = ({in_ca, in_sum} != check);
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            S_EMPTY: begin
                if (push) begin
                    head_d  = new_entry;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                case ({push, pop})
                    2'b10: begin
                        tail_d  = new_entry;
                        state_d = S_FULL;
                    end
                    2'b01:   state_d = S_EMPTY;
                    2'b11:   head_d  = new_entry;
                    default: ;
                endcase
            end
            S_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= (state_d != S_FULL);
        end
    end

    // A clear in the same cycle as a push drops that op from the statistics.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            op_count_q   <= '0;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else if (push) begin
            if (op_count_q != CNT_MAX) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
            if (new_entry.err) begin
                err_sticky_q <= 1'b1;
                if (err_count_q != CNT_MAX) begin
                    err_count_q <= err_count_q + CNT_W'(1);
                end
            end
        end
    end

    assign out_result = head_q.result;
    assign out_carry  = head_q.carry;
    assign out_borrow = head_q.borrow;
    assign out_zero   = head_q.zero;
    assign out_neg    = head_q.neg;
    assign out_ovf    = head_q.ovf;
    assign out_err    = head_q.err;
    assign op_count   = op_count_q;
    assign err_count  = err_count_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_addsub_result_stage.sv
// Scoreboard bench for addsub_result_stage: driver queues expected entries on acceptance,
// an independent monitor pops and compares on every downstream transfer.
module tb_addsub_result_stage;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_sub = 1'b0;
    logic          in_ca = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_stats = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [W-1:0]  in_sum = '0;
    logic          in_ready, out_valid;
    logic [W-1:0]  out_result;
    logic          out_carry, out_borrow, out_zero, out_neg, out_ovf, out_err;
    logic [CW-1:0] op_count, err_count;
    logic          err_sticky;

    addsub_result_stage #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
        .in_a(in_a), .in_b(in_b), .in_sum(in_sum), .in_ca(in_ca),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_carry(out_carry), .out_borrow(out_borrow),
        .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf), .out_err(out_err),
        .clr_stats(clr_stats), .op_count(op_count), .err_count(err_count),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         failures = 0;
    logic [9:0] exp_q[$];
    int         op_m = 0;
    int         err_m = 0;
    logic       sticky_m = 1'b0;
    bit         rand_done = 1'b0;
    logic [9:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the correct answer is plain integer a+b or a-b; flags follow the signed view.
    function automatic logic [9:0] model(input logic [3:0] a, input logic [3:0] b, input logic sub,
                                         input logic [3:0] sum, input logic ca);
        int ia = int'(a);
        int ib = int'(b);
        int good, sa, sb, ss;
        logic good_ca, err, ovf, borrow, zero, neg;
        logic [3:0] good_sum;
        if (sub) begin
            good    = ia - ib;
            good_ca = (ia >= ib);
        end else begin
            good    = ia + ib;
            good_ca = (good > 15);
        end
        good_sum = good[3:0];
        err      = (sum != good_sum) || (ca != good_ca);
        sa       = a[3] ? ia - 16 : ia;
        sb       = b[3] ? ib - 16 : ib;
        ss       = sum[3] ? int'(sum) - 16 : int'(sum);
        if (sub) ovf = ((sa < 0) != (sb < 0)) && ((ss < 0) != (sa < 0));
        else     ovf = ((sa < 0) == (sb < 0)) && ((ss < 0) != (sa < 0));
        borrow = sub && !ca;
        zero   = (sum == 4'd0);
        neg    = (ss < 0);
        return {sum, ca, borrow, zero, neg, ovf, err};
    endfunction

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic sub,
                         input logic [3:0] sum, input logic ca);
        bit         acc = 1'b0;
        int         n = 0;
        logic [9:0] e;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_sub = sub; in_sum = sum; in_ca = ca;
        while (!acc && n < 64) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                e = model(a, b, sub, sum, ca);
                exp_q.push_back(e);
                if (clr_stats) begin
                    op_m = 0; err_m = 0; sticky_m = 1'b0;
                end else begin
                    if (op_m < 255) op_m++;
                    if (e[0]) begin
                        if (err_m < 255) err_m++;
                        sticky_m = 1'b1;
                    end
                end
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            checks++; failures++;
            $display("FAIL issue_timeout: got not accepted expected accepted within 64 cycles");
        end
    endtask

    task automatic rand_op(input bit allow_err);
        logic [3:0] a, b, sum;
        logic sub, ca;
        int r;
        a   = 4'($urandom_range(0, 15));
        b   = 4'($urandom_range(0, 15));
        sub = 1'($urandom_range(0, 1));
        if (sub) begin
            r = int'(a) - int'(b); ca = (a >= b);
        end else begin
            r = int'(a) + int'(b); ca = (r > 15);
        end
        sum = r[3:0];
        if (allow_err && $urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) ca = ~ca;
            else sum = sum ^ 4'($urandom_range(1, 15));
        end
        issue(a, b, sub, sum, ca);
    endtask

    task automatic check_stats(input string name);
        chk({name, "_op"}, 32'(op_count), 32'(op_m));
        chk({name, "_err"}, 32'(err_count), 32'(err_m));
        chk({name, "_sticky"}, 32'(err_sticky), 32'(sticky_m));
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        op_m = 0; err_m = 0; sticky_m = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL pop_unexpected: got output result %0h expected no entry", out_result);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_entry", 32'({out_result, out_carry, out_borrow, out_zero, out_neg, out_ovf, out_err}),
                    32'(mon_e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_outs", 32'({out_valid, out_result, out_carry, out_borrow, out_zero, out_neg, out_ovf, out_err}), 32'd0);
        chk("rst_counts", 32'({op_count, err_count, err_sticky}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);

        out_ready = 1'b1;
        issue(4'b0001, 4'b1110, 1'b0, 4'b1111, 1'b0);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_fields", 32'({out_result, out_carry, out_neg, out_ovf, out_err}), 32'({4'b1111, 4'b0100}));
        chk("add_opcount", 32'(op_count), 32'd1);
        issue(4'b0111, 4'b1001, 1'b1, 4'b1110, 1'b0);
        chk("sub1_flags", 32'({out_ovf, out_borrow, out_neg, out_err}), 32'({4'b1110}));
        issue(4'b0101, 4'b0110, 1'b1, 4'b1111, 1'b0);
        chk("sub2_flags", 32'({out_ovf, out_borrow}), 32'({2'b01}));
        wait_drain("basic_drain");
        check_stats("basic");

        out_ready = 1'b0;
        issue(4'd2, 4'd3, 1'b0, 4'd5, 1'b0);
        issue(4'd4, 4'd1, 1'b1, 4'd3, 1'b1);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_head", 32'(out_result), 32'd5);
        fork
            issue(4'd6, 4'd6, 1'b0, 4'd12, 1'b0);
            begin
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("bp_hold_ready", 32'(in_ready), 32'd0);
                end
                chk("bp_hold_opcount", 32'(op_count), 32'd5);
                out_ready = 1'b1;
            end
        join
        wait_drain("bp_drain");
        check_stats("bp");

        clear_stats();
        issue(4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0);
        chk("err_head", 32'(out_err), 32'd1);
        chk("err_count", 32'(err_count), 32'd1);
        chk("err_sticky", 32'(err_sticky), 32'd1);
        wait_drain("err_drain");
        clear_stats();
        chk("clr_all", 32'({op_count, err_count, err_sticky}), 32'd0);

        clr_stats = 1'b1;
        issue(4'd3, 4'd3, 1'b0, 4'd6, 1'b0);
        clr_stats = 1'b0;
        chk("clr_push_op", 32'(op_count), 32'd0);
        wait_drain("clr_drain");

        fork
            begin
                for (int i = 0; i < 300; i++) rand_op(1'b1);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("rand_drain");
        check_stats("rand");

        clear_stats();
        for (int i = 0; i < 260; i++) rand_op(1'b0);
        wait_drain("sat_drain");
        chk("sat_op", 32'(op_count), 32'd255);
        check_stats("sat");

        out_ready = 1'b0;
        issue(4'd1, 4'd2, 1'b0, 4'd3, 1'b0);
        issue(4'd9, 4'd4, 1'b1, 4'd5, 1'b1);
        chk("mid_full_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        op_m = 0; err_m = 0; sticky_m = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rel_ready", 32'(in_ready), 32'd1);
        check_stats("mid_rst");
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_lost", 32'(out_valid), 32'd0);
        chk("final_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
